// File: rtl/rssi_cca_pkg.sv
// ----------------------------------------------------------------------------
// rssi_cca_pkg
// Shared definitions for the energy-detect clear-channel assessment block:
//   - cca_state_t : 2-bit FSM state encoding (IDLE, BUSY_PEND, BUSY, IDLE_PEND)
//   - rssi_most_neg() : most-negative two's complement value of a given width,
//                       used as the reset / cleared value of the peak hold
// ----------------------------------------------------------------------------
package rssi_cca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY_PEND = 2'd1,
        ST_BUSY      = 2'd2,
        ST_IDLE_PEND = 2'd3
    } cca_state_t;

    // 1 followed by zeros at the requested width (e.g. -1024 for width 11)
    function automatic int rssi_most_neg(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; once the count reaches all-ones it holds there.
// Ports:
//   i_clk   : clock
//   i_rstn  : asynchronous active-low reset (count -> 0)
//   i_clr   : synchronous clear (count -> 0), wins over i_inc
//   i_inc   : increment request
//   o_cnt   : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rssi_cca_ed.sv
// ----------------------------------------------------------------------------
// rssi_cca_ed
// Energy-detect clear-channel assessment on a 0.5 dB RSSI sample stream.
// Produces a debounced, hysteretic channel-busy decision for CSMA/backoff,
// plus busy-time statistics and a peak-RSSI hold for software.
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset
//   rssi_half_db        : signed RSSI sample (0.5 dB step)
//   rssi_half_db_valid  : sample strobe
//   rssi_th_half_db     : signed busy threshold
//   rssi_hyst_half_db   : unsigned hysteresis below threshold for idle
//   min_busy_samples    : consecutive samples >= th to declare busy (0 acts as 1)
//   min_idle_samples    : consecutive samples < th-hyst to declare idle (0 acts as 1)
//   tx_on               : local transmit active, forces busy
//   stat_clear          : clears counters and peak (wins over a coincident sample)
//   ch_busy             : registered busy decision
//   busy_rise/busy_fall : one-cycle strobes coincident with ch_busy edges
//   busy_sample_cnt     : samples seen while ch_busy was 1 (saturating)
//   total_sample_cnt    : all samples seen (saturating)
//   rssi_peak_half_db   : maximum RSSI since last clear
// ----------------------------------------------------------------------------
module rssi_cca_ed
    import rssi_cca_pkg::*;
#(
    parameter int RSSI_HALF_DB_WIDTH = 11,
    parameter int HYST_WIDTH         = 5,
    parameter int DEBOUNCE_WIDTH     = 8,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
    input  logic                          rssi_half_db_valid,
    input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_th_half_db,
    input  logic [HYST_WIDTH-1:0]         rssi_hyst_half_db,
    input  logic [DEBOUNCE_WIDTH-1:0]     min_busy_samples,
    input  logic [DEBOUNCE_WIDTH-1:0]     min_idle_samples,
    input  logic                          tx_on,
    input  logic                          stat_clear,
    output logic                          ch_busy,
    output logic                          busy_rise,
    output logic                          busy_fall,
    output logic [CNT_WIDTH-1:0]          busy_sample_cnt,
    output logic [CNT_WIDTH-1:0]          total_sample_cnt,
    output logic [RSSI_HALF_DB_WIDTH-1:0] rssi_peak_half_db
);

    localparam int RW = RSSI_HALF_DB_WIDTH;
    localparam logic [RW-1:0] PEAK_INIT = RW'(rssi_most_neg(RW));

    cca_state_t                r_state;
    cca_state_t                w_state_nxt;
    logic [DEBOUNCE_WIDTH-1:0] r_cnt;
    logic [DEBOUNCE_WIDTH-1:0] w_cnt_nxt;
    logic [DEBOUNCE_WIDTH-1:0] w_cnt_inc;
    logic [DEBOUNCE_WIDTH-1:0] w_busy_tgt;
    logic [DEBOUNCE_WIDTH-1:0] w_idle_tgt;
    logic                      r_ch_busy;
    logic                      r_rise;
    logic                      r_fall;
    logic                      w_busy_nxt;
    logic [RW-1:0]             r_peak;

    logic signed [RW-1:0]      w_rssi;
    logic signed [RW-1:0]      w_th;
    logic signed [RW:0]        w_rssi_ext;
    logic signed [RW:0]        w_th_lo;
    logic                      w_ge_th;
    logic                      w_lt_lo;

    // Idle threshold is formed one bit wider so th - hyst never wraps
    assign w_rssi     = $signed(rssi_half_db);
    assign w_th       = $signed(rssi_th_half_db);
    assign w_rssi_ext = $signed({rssi_half_db[RW-1], rssi_half_db});
    assign w_th_lo    = $signed({rssi_th_half_db[RW-1], rssi_th_half_db})
                      - $signed({{(RW + 1 - HYST_WIDTH){1'b0}}, rssi_hyst_half_db});
    assign w_ge_th    = (w_rssi >= w_th);
    assign w_lt_lo    = (w_rssi_ext < w_th_lo);

    // A debounce target of 0 is treated as 1 so a single sample decides
    assign w_busy_tgt = (min_busy_samples == '0) ? DEBOUNCE_WIDTH'(1) : min_busy_samples;
    assign w_idle_tgt = (min_idle_samples == '0) ? DEBOUNCE_WIDTH'(1) : min_idle_samples;
    assign w_cnt_inc  = r_cnt + DEBOUNCE_WIDTH'(1);

    // Next-state: targets may change mid-pend, so ">=" lets a lowered target
    // terminate the pend on the next qualifying sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (tx_on) begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = '0;
        end else if (rssi_half_db_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ge_th) begin
                        w_cnt_nxt   = DEBOUNCE_WIDTH'(1);
                        w_state_nxt = (w_busy_tgt <= DEBOUNCE_WIDTH'(1)) ? ST_BUSY : ST_BUSY_PEND;
                    end
                end
                ST_BUSY_PEND: begin
                    if (w_ge_th) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= w_busy_tgt) begin
                            w_state_nxt = ST_BUSY;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_BUSY: begin
                    if (w_lt_lo) begin
                        w_cnt_nxt   = DEBOUNCE_WIDTH'(1);
                        w_state_nxt = (w_idle_tgt <= DEBOUNCE_WIDTH'(1)) ? ST_IDLE : ST_IDLE_PEND;
                    end
                end
                ST_IDLE_PEND: begin
                    if (w_lt_lo) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= w_idle_tgt) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign w_busy_nxt = (w_state_nxt == ST_BUSY) || (w_state_nxt == ST_IDLE_PEND);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ch_busy <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ch_busy <= w_busy_nxt;
            r_rise    <= w_busy_nxt & ~r_ch_busy;
            r_fall    <= ~w_busy_nxt & r_ch_busy;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_peak <= PEAK_INIT;
        end else if (stat_clear) begin
            r_peak <= PEAK_INIT;
        end else if (rssi_half_db_valid && (w_rssi > $signed(r_peak))) begin
            r_peak <= rssi_half_db;
        end
    end

    // Busy samples are qualified by the decision already registered when the
    // sample arrives, not by the decision that sample produces.
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_total_cnt (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_clr  (stat_clear),
        .i_inc  (rssi_half_db_valid),
        .o_cnt  (total_sample_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_busy_cnt (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_clr  (stat_clear),
        .i_inc  (rssi_half_db_valid & r_ch_busy),
        .o_cnt  (busy_sample_cnt)
    );

    assign ch_busy           = r_ch_busy;
    assign busy_rise         = r_rise;
    assign busy_fall         = r_fall;
    assign rssi_peak_half_db = r_peak;

endmodule

// File: tb/tb_rssi_cca_ed.sv
module tb_rssi_cca_ed;

    logic        clk = 1'b0;
    logic        rstn;
    logic [10:0] rssi_half_db;
    logic        rssi_half_db_valid;
    logic [10:0] rssi_th_half_db;
    logic [4:0]  rssi_hyst_half_db;
    logic [7:0]  min_busy_samples;
    logic [7:0]  min_idle_samples;
    logic        tx_on;
    logic        stat_clear;

    logic        ch_busy, busy_rise, busy_fall;
    logic [31:0] busy_sample_cnt, total_sample_cnt;
    logic [10:0] rssi_peak_half_db;

    logic        s_ch_busy, s_busy_rise, s_busy_fall;
    logic [3:0]  s_busy_cnt, s_total_cnt;
    logic [10:0] s_peak;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic  busy;
        logic  rise;
        logic  fall;
        string tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rssi_cca_ed dut (
        .clk                (clk),
        .rstn               (rstn),
        .rssi_half_db       (rssi_half_db),
        .rssi_half_db_valid (rssi_half_db_valid),
        .rssi_th_half_db    (rssi_th_half_db),
        .rssi_hyst_half_db  (rssi_hyst_half_db),
        .min_busy_samples   (min_busy_samples),
        .min_idle_samples   (min_idle_samples),
        .tx_on              (tx_on),
        .stat_clear         (stat_clear),
        .ch_busy            (ch_busy),
        .busy_rise          (busy_rise),
        .busy_fall          (busy_fall),
        .busy_sample_cnt    (busy_sample_cnt),
        .total_sample_cnt   (total_sample_cnt),
        .rssi_peak_half_db  (rssi_peak_half_db)
    );

    // Narrow-counter copy, driven identically, for the saturation check
    rssi_cca_ed #(.CNT_WIDTH(4)) dut_sat (
        .clk                (clk),
        .rstn               (rstn),
        .rssi_half_db       (rssi_half_db),
        .rssi_half_db_valid (rssi_half_db_valid),
        .rssi_th_half_db    (rssi_th_half_db),
        .rssi_hyst_half_db  (rssi_hyst_half_db),
        .min_busy_samples   (min_busy_samples),
        .min_idle_samples   (min_idle_samples),
        .tx_on              (tx_on),
        .stat_clear         (stat_clear),
        .ch_busy            (s_ch_busy),
        .busy_rise          (s_busy_rise),
        .busy_fall          (s_busy_fall),
        .busy_sample_cnt    (s_busy_cnt),
        .total_sample_cnt   (s_total_cnt),
        .rssi_peak_half_db  (s_peak)
    );

    function automatic logic [31:0] sx11(input logic [10:0] v);
        return {{21{v[10]}}, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    // Drive one cycle of inputs, queue the expected decision outputs, and
    // compare them against the DUT one edge later.
    task automatic step(input logic v, input int r, input logic tx, input logic clr,
                        input logic eb, input logic er, input logic ef, input string tag);
        exp_t e;
        rssi_half_db       = 11'(r);
        rssi_half_db_valid = v;
        tx_on              = tx;
        stat_clear         = clr;
        sb.push_back('{busy: eb, rise: er, fall: ef, tag: tag});
        @(posedge clk);
        #1;
        rssi_half_db_valid = 1'b0;
        stat_clear         = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".busy"}, {31'd0, ch_busy},   {31'd0, e.busy});
            chk({e.tag, ".rise"}, {31'd0, busy_rise}, {31'd0, e.rise});
            chk({e.tag, ".fall"}, {31'd0, busy_fall}, {31'd0, e.fall});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn               = 1'b0;
        rssi_half_db       = '0;
        rssi_half_db_valid = 1'b0;
        rssi_th_half_db    = 11'(-120);
        rssi_hyst_half_db  = 5'd6;
        min_busy_samples   = 8'd3;
        min_idle_samples   = 8'd4;
        tx_on              = 1'b0;
        stat_clear         = 1'b0;

        // Reset state
        #12;
        chk("rst.busy",  {31'd0, ch_busy}, 32'd0);
        chk("rst.total", total_sample_cnt, 32'd0);
        chk("rst.bcnt",  busy_sample_cnt, 32'd0);
        chk("rst.peak",  sx11(rssi_peak_half_db), 32'(-1024));
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Busy debounce: interrupted run, then three consecutive
        step(1, -100, 0, 0, 0, 0, 0, "deb1");
        step(1, -100, 0, 0, 0, 0, 0, "deb2");
        step(1, -130, 0, 0, 0, 0, 0, "deb_brk");
        step(1, -100, 0, 0, 0, 0, 0, "deb3");
        step(1, -100, 0, 0, 0, 0, 0, "deb4");
        step(1, -100, 0, 0, 1, 1, 0, "deb5");
        step(0, -100, 0, 0, 1, 0, 0, "deb_hold");

        // Hysteresis: th_lo = -126; -124 and -126 keep busy, -127 counts
        for (int i = 0; i < 10; i++) step(1, -124, 0, 0, 1, 0, 0, "hys_in");
        step(1, -126, 0, 0, 1, 0, 0, "hys_edge");
        for (int i = 0; i < 3; i++) step(1, -127, 0, 0, 1, 0, 0, "hys_pend");
        step(1, -127, 0, 0, 0, 0, 1, "hys_fall");
        step(0, -127, 0, 0, 0, 0, 0, "hys_hold");

        // tx_on override
        step(1, -200, 0, 0, 0, 0, 0, "tx_idle");
        step(0, -200, 1, 0, 1, 1, 0, "tx_rise");
        for (int i = 0; i < 4; i++) step(0, -200, 1, 0, 1, 0, 0, "tx_on");
        for (int i = 0; i < 3; i++) step(1, -200, 0, 0, 1, 0, 0, "tx_rel");
        step(1, -200, 0, 0, 0, 0, 1, "tx_fall");

        // Coincident clear: sample not counted, FSM still advances
        step(1, -50, 0, 1, 0, 0, 0, "clr_co");
        chk("clr_co.total", total_sample_cnt, 32'd0);
        chk("clr_co.bcnt",  busy_sample_cnt, 32'd0);
        chk("clr_co.peak",  sx11(rssi_peak_half_db), 32'(-1024));

        // Statistics: 10 samples, 6 taken while ch_busy=1
        step(1, -90,  0, 0, 0, 0, 0, "st1");
        step(1, -95,  0, 0, 1, 1, 0, "st2");
        step(1, -100, 0, 0, 1, 0, 0, "st3");
        step(1, -100, 0, 0, 1, 0, 0, "st4");
        step(1, -130, 0, 0, 1, 0, 0, "st5");
        step(1, -130, 0, 0, 1, 0, 0, "st6");
        step(1, -130, 0, 0, 1, 0, 0, "st7");
        step(1, -130, 0, 0, 0, 0, 1, "st8");
        step(1, -130, 0, 0, 0, 0, 0, "st9");
        step(1, -130, 0, 0, 0, 0, 0, "st10");
        chk("st.total", total_sample_cnt, 32'd10);
        chk("st.bcnt",  busy_sample_cnt, 32'd6);
        chk("st.peak",  sx11(rssi_peak_half_db), 32'(-90));

        // Saturation: 20 samples into 32-bit and 4-bit counters
        step(0, -130, 0, 1, 0, 0, 0, "sat_clr");
        chk("sat_clr.total", total_sample_cnt, 32'd0);
        for (int i = 0; i < 20; i++) step(1, -130, 0, 0, 0, 0, 0, "sat");
        chk("sat.total32", total_sample_cnt, 32'd20);
        chk("sat.total4",  {28'd0, s_total_cnt}, 32'd15);
        chk("sat.bcnt4",   {28'd0, s_busy_cnt}, 32'd0);

        // Zero debounce targets act as one; -120 is exactly at threshold
        min_busy_samples = 8'd0;
        min_idle_samples = 8'd0;
        step(1, -120, 0, 0, 1, 1, 0, "zb_busy");
        step(1, -130, 0, 0, 0, 0, 1, "zi_idle");
        chk("zb.total", total_sample_cnt, 32'd22);
        chk("zb.bcnt",  busy_sample_cnt, 32'd1);
        chk("zb.peak",  sx11(rssi_peak_half_db), 32'(-120));

        // Clear coincident with a deciding sample: busy still asserts
        step(1, -60, 0, 1, 1, 1, 0, "clr2");
        chk("clr2.total", total_sample_cnt, 32'd0);
        chk("clr2.peak",  sx11(rssi_peak_half_db), 32'(-1024));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
